// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings, command opcodes, sequencer
// phases and the IEEE 1149.1 TAP next-state function.
package jtag_pkg;

  typedef enum logic [4:0] {
    TAP_TEST_LOGIC_RESET = 5'd0,
    TAP_RUN_TEST_IDLE    = 5'd1,
    TAP_SELECT_DR_SCAN   = 5'd2,
    TAP_CAPTURE_DR       = 5'd3,
    TAP_SHIFT_DR         = 5'd4,
    TAP_EXIT1_DR         = 5'd5,
    TAP_PAUSE_DR         = 5'd6,
    TAP_EXIT2_DR         = 5'd7,
    TAP_UPDATE_DR        = 5'd8,
    TAP_SELECT_IR_SCAN   = 5'd9,
    TAP_CAPTURE_IR       = 5'd10,
    TAP_SHIFT_IR         = 5'd11,
    TAP_EXIT1_IR         = 5'd12,
    TAP_PAUSE_IR         = 5'd13,
    TAP_EXIT2_IR         = 5'd14,
    TAP_UPDATE_IR        = 5'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_IDLE    = 2'd1,
    OP_IR_SCAN = 2'd2,
    OP_DR_SCAN = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_ENTER,
    SEQ_PRE,
    SEQ_SHIFT,
    SEQ_POST,
    SEQ_RUN,
    SEQ_RESP
  } seq_state_t;

  // TMS bits that follow the leading 1 of each preamble, LSB presented first
  localparam logic [4:0] PRE_TAIL_RESET = 5'b01111;
  localparam logic [4:0] PRE_TAIL_IR    = 5'b00001;
  localparam logic [4:0] PRE_TAIL_DR    = 5'b00000;

  function automatic tap_state_t next_tap_state(input tap_state_t state, input logic tms);
    tap_state_t nxt;
    case (state)
      TAP_TEST_LOGIC_RESET: nxt = tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
      TAP_RUN_TEST_IDLE:    nxt = tms ? TAP_SELECT_DR_SCAN   : TAP_RUN_TEST_IDLE;
      TAP_SELECT_DR_SCAN:   nxt = tms ? TAP_SELECT_IR_SCAN   : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR:       nxt = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
      TAP_SHIFT_DR:         nxt = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
      TAP_EXIT1_DR:         nxt = tms ? TAP_UPDATE_DR        : TAP_PAUSE_DR;
      TAP_PAUSE_DR:         nxt = tms ? TAP_EXIT2_DR         : TAP_PAUSE_DR;
      TAP_EXIT2_DR:         nxt = tms ? TAP_UPDATE_DR        : TAP_SHIFT_DR;
      TAP_UPDATE_DR:        nxt = tms ? TAP_SELECT_DR_SCAN   : TAP_RUN_TEST_IDLE;
      TAP_SELECT_IR_SCAN:   nxt = tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR:       nxt = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
      TAP_SHIFT_IR:         nxt = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
      TAP_EXIT1_IR:         nxt = tms ? TAP_UPDATE_IR        : TAP_PAUSE_IR;
      TAP_PAUSE_IR:         nxt = tms ? TAP_EXIT2_IR         : TAP_PAUSE_IR;
      TAP_EXIT2_IR:         nxt = tms ? TAP_UPDATE_IR        : TAP_SHIFT_IR;
      TAP_UPDATE_IR:        nxt = tms ? TAP_SELECT_DR_SCAN   : TAP_RUN_TEST_IDLE;
      default:              nxt = TAP_TEST_LOGIC_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_scan_sequencer_if.sv
// Command/response handshake between a scan command source (master) and the
// scan sequencer (slave).
interface jtag_scan_sequencer_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_tap_mirror.sv
// Tracks the target TAP state from the TMS value presented each tck cycle.
module jtag_tap_mirror
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t tap_state
);

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      tap_state <= TAP_TEST_LOGIC_RESET;
    end else begin
      tap_state <= next_tap_state(tap_state, tms);
    end
  end

endmodule

// File: rtl/jtag_scan_sequencer.sv
// Host-side JTAG scan engine: turns RESET/IDLE/IR/DR commands into registered
// TMS/TDI sequences and returns the captured TDO bits.
module jtag_scan_sequencer
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 8
) (
  input  logic                 tck,
  input  logic                 trst,
  jtag_scan_sequencer_if.slave bus,
  output logic                 tms,
  output logic                 tdi,
  input  logic                 tdo,
  output tap_state_t           tap_state,
  output logic                 busy
);

  localparam int               IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  seq_state_t         state;
  cmd_op_t            op_r;
  logic [LEN_W-1:0]   cnt;
  logic [4:0]         pre_tail;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last_idx;
  logic [MAX_LEN-1:0] shreg;
  logic [MAX_LEN-1:0] cap;
  logic               cmd_ready_r;
  logic               rsp_valid_r;
  logic               rsp_err_r;
  logic [MAX_LEN-1:0] rsp_data_r;

  cmd_op_t            cmd_op_in;
  logic [LEN_W-1:0]   len_m1;
  logic [IDX_W-1:0]   idx_next;
  logic               len_bad;
  logic               in_tlr;

  assign cmd_op_in = cmd_op_t'(bus.cmd_op);
  assign len_m1    = bus.cmd_len - 1'b1;
  assign idx_next  = idx + 1'b1;
  assign len_bad   = (bus.cmd_len == '0) || (bus.cmd_len > LEN_MAX);
  assign in_tlr    = (tap_state == TAP_TEST_LOGIC_RESET);

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_data  = rsp_data_r;

  jtag_tap_mirror u_tap_mirror (
    .tck       (tck),
    .trst      (trst),
    .tms       (tms),
    .tap_state (tap_state)
  );

  // Each edge decides the TMS/TDI for the coming cycle, so tms always leads the mirror by one cycle
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state       <= SEQ_IDLE;
      op_r        <= OP_RESET;
      cnt         <= '0;
      pre_tail    <= '0;
      idx         <= '0;
      last_idx    <= '0;
      shreg       <= '0;
      cap         <= '0;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= '0;
      tms         <= 1'b1;
      tdi         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          cmd_ready_r <= 1'b1;
          if (bus.cmd_valid && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            op_r        <= cmd_op_in;
            shreg       <= bus.cmd_data;
            cap         <= '0;
            idx         <= '0;
            last_idx    <= len_m1[IDX_W-1:0];
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= '0;
            case (cmd_op_in)
              OP_RESET: begin
                state    <= SEQ_PRE;
                cnt      <= LEN_W'(6);
                pre_tail <= PRE_TAIL_RESET;
                tms      <= 1'b1;
                busy     <= 1'b1;
              end
              OP_IDLE: begin
                cnt <= bus.cmd_len;
                if (bus.cmd_len == '0) begin
                  state       <= SEQ_RESP;
                  rsp_valid_r <= 1'b1;
                end else begin
                  state <= in_tlr ? SEQ_ENTER : SEQ_RUN;
                  tms   <= 1'b0;
                  busy  <= 1'b1;
                end
              end
              default: begin
                cnt      <= (cmd_op_in == OP_IR_SCAN) ? LEN_W'(4) : LEN_W'(3);
                pre_tail <= (cmd_op_in == OP_IR_SCAN) ? PRE_TAIL_IR : PRE_TAIL_DR;
                // A rejected scan never touches the TAP, so tms keeps its idle value
                if (len_bad) begin
                  state       <= SEQ_RESP;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= 1'b1;
                end else if (in_tlr) begin
                  state <= SEQ_ENTER;
                  tms   <= 1'b0;
                  busy  <= 1'b1;
                end else begin
                  state <= SEQ_PRE;
                  tms   <= 1'b1;
                  busy  <= 1'b1;
                end
              end
            endcase
          end
        end

        SEQ_ENTER: begin
          if (op_r == OP_IDLE) begin
            state <= SEQ_RUN;
            tms   <= 1'b0;
          end else begin
            state <= SEQ_PRE;
            tms   <= 1'b1;
          end
        end

        SEQ_PRE: begin
          if (cnt > LEN_W'(1)) begin
            cnt      <= cnt - 1'b1;
            tms      <= pre_tail[0];
            pre_tail <= pre_tail >> 1;
          end else if (op_r == OP_RESET) begin
            state       <= SEQ_RESP;
            rsp_valid_r <= 1'b1;
            busy        <= 1'b0;
          end else begin
            state <= SEQ_SHIFT;
            tms   <= (last_idx == '0);
            tdi   <= shreg[0];
            shreg <= shreg >> 1;
          end
        end

        SEQ_SHIFT: begin
          cap[idx] <= tdo;
          if (idx == last_idx) begin
            state <= SEQ_POST;
            tms   <= 1'b1;
            tdi   <= 1'b0;
          end else begin
            idx   <= idx_next;
            tdi   <= shreg[0];
            shreg <= shreg >> 1;
            tms   <= (idx_next == last_idx);
          end
        end

        // Two cycles: tms=1 to Update, then tms=0 back to RunTestOrIdle
        SEQ_POST: begin
          if (tms) begin
            tms <= 1'b0;
          end else begin
            state       <= SEQ_RESP;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= cap;
            busy        <= 1'b0;
          end
        end

        SEQ_RUN: begin
          if (cnt > LEN_W'(1)) begin
            cnt <= cnt - 1'b1;
          end else begin
            state       <= SEQ_RESP;
            rsp_valid_r <= 1'b1;
            busy        <= 1'b0;
          end
        end

        SEQ_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state       <= SEQ_IDLE;
          end
        end

        default: begin
          state <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer: a scoreboard of expected responses
// and TMS/TDI traces built from the command, compared as each response arrives.
module tb_jtag_scan_sequencer;
  import jtag_pkg::*;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 8;

  logic       tck = 1'b0;
  logic       trst = 1'b1;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       busy;
  tap_state_t tap_state;
  logic       tdo_high = 1'b0;
  bit         in_tlr = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    logic [63:0] tms_seq;
    logic [31:0] tdi_bits;
    int          len;
    int          shift_start;
    bit          end_tlr;
    logic        end_tms;
  } exp_t;

  exp_t sb[$];

  jtag_scan_sequencer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_scan_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tck       (tck),
    .trst      (trst),
    .bus       (bus),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tap_state (tap_state),
    .busy      (busy)
  );

  always #5 tck = ~tck;

  // Target is either a loopback (tdo follows tdi) or a constant-1 source
  assign tdo = tdo_high ? 1'b1 : tdi;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  function automatic logic [31:0] lenMask(input int len);
    if (len >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << len) - 32'd1;
  endfunction

  function automatic exp_t buildExpected(input logic [1:0] op, input int len, input logic [31:0] data,
                                         input bit from_tlr, input bit tied);
    exp_t e;
    int   pos;
    bit   bad;
    e.data = '0; e.err = 1'b0; e.lat = 0; e.tms_seq = '0; e.tdi_bits = '0;
    e.len = 0; e.shift_start = 0; e.end_tlr = 1'b0; e.end_tms = 1'b0;
    bad = (op >= 2'd2) && (len == 0 || len > MAX_LEN);
    if (bad || (op == 2'd1 && len == 0)) begin
      e.err     = bad;
      e.end_tlr = from_tlr;
      e.end_tms = from_tlr;
      return e;
    end
    pos = 0;
    if (op != 2'd0 && from_tlr) pos++;
    case (op)
      2'd0: begin
        for (int i = 0; i < 5; i++) e.tms_seq[i] = 1'b1;
        pos += 6;
      end
      2'd1: pos += len;
      default: begin
        e.tms_seq[pos] = 1'b1;
        if (op == 2'd2) begin
          e.tms_seq[pos+1] = 1'b1;
          pos += 4;
        end else begin
          pos += 3;
        end
        e.shift_start = pos;
        e.len         = len;
        e.tdi_bits    = data & lenMask(len);
        e.data        = tied ? lenMask(len) : (data & lenMask(len));
        pos += len;
        e.tms_seq[pos-1] = 1'b1;
        e.tms_seq[pos]   = 1'b1;
        pos += 2;
      end
    endcase
    e.lat = pos;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after acceptance
  task automatic applyStimulus(input logic [1:0] op, input int len, input logic [31:0] data, input bit expect_rsp);
    exp_t e;
    int   waited;
    e = buildExpected(op, len, data, in_tlr, tdo_high);
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge tck);
      waited++;
    end
    checkOutput("cmd_ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_data  = data;
    if (expect_rsp) sb.push_back(e);
    @(negedge tck);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic ackResponse();
    bus.rsp_ready = 1'b1;
    @(negedge tck);
    bus.rsp_ready = 1'b0;
    checkOutput("rsp_valid_after_ack", bus.rsp_valid, 0);
    checkOutput("cmd_ready_after_ack", bus.cmd_ready, 1);
  endtask

  task automatic waitResponse(input bit ack);
    exp_t        e;
    logic [63:0] tv, bv, dv;
    logic [31:0] got_tdi;
    int          c;
    tv = '0; bv = '0; dv = '0; c = 0;
    while (bus.rsp_valid !== 1'b1 && c < 100) begin
      if (c < 64) begin
        tv[c] = tms;
        dv[c] = tdi;
        bv[c] = busy;
      end
      c++;
      @(negedge tck);
    end
    checkOutput("rsp_valid_seen", bus.rsp_valid, 1);
    checkOutput("sb_has_entry", (sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkOutput("latency", c, e.lat);
    checkOutput("tms_trace", tv, e.tms_seq);
    checkOutput("busy_trace", bv, (64'd1 << e.lat) - 64'd1);
    checkOutput("rsp_data", bus.rsp_data, e.data);
    checkOutput("rsp_err", bus.rsp_err, e.err);
    checkOutput("tap_state_end", tap_state, e.end_tlr ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE);
    checkOutput("tms_at_rsp", tms, e.end_tms);
    checkOutput("busy_at_rsp", busy, 0);
    checkOutput("cmd_ready_at_rsp", bus.cmd_ready, 0);
    if (e.len > 0) begin
      got_tdi = '0;
      for (int k = 0; k < e.len; k++) got_tdi[k] = dv[e.shift_start + k];
      checkOutput("tdi_shift_bits", got_tdi, e.tdi_bits);
    end
    in_tlr = e.end_tlr;
    if (ack) ackResponse();
  endtask

  initial begin
    bit saw_rsp;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    #2 trst = 1'b0;
    repeat (2) @(negedge tck);
    checkOutput("reset_tms", tms, 1);
    checkOutput("reset_tdi", tdi, 0);
    checkOutput("reset_cmd_ready", bus.cmd_ready, 0);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_rsp_data", bus.rsp_data, 0);
    checkOutput("reset_rsp_err", bus.rsp_err, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_tap_state", tap_state, TAP_TEST_LOGIC_RESET);
    trst = 1'b1;
    @(negedge tck);
    checkOutput("ready_after_release", bus.cmd_ready, 1);

    $display("[TB] IR scan from TestLogicReset, loopback");
    tdo_high = 1'b0;
    applyStimulus(2'd2, 5, 32'h16, 1'b1);
    waitResponse(1'b1);
    checkOutput("idle_tms_after_cmd", tms, 0);

    $display("[TB] RESET command");
    applyStimulus(2'd0, 0, 32'h0, 1'b1);
    waitResponse(1'b1);

    $display("[TB] DR scan 32 bits, tdo tied high");
    tdo_high = 1'b1;
    applyStimulus(2'd3, 32, 32'hDEADBEEF, 1'b1);
    waitResponse(1'b1);
    tdo_high = 1'b0;

    $display("[TB] DR scan 1 bit, loopback");
    applyStimulus(2'd3, 1, 32'h1, 1'b1);
    waitResponse(1'b1);

    $display("[TB] Rejected lengths 0 and 33");
    applyStimulus(2'd3, 0, 32'h5, 1'b1);
    waitResponse(1'b1);
    applyStimulus(2'd3, 33, 32'hA5A5_A5A5, 1'b1);
    waitResponse(1'b1);

    $display("[TB] IDLE 3 cycles with delayed rsp_ready");
    applyStimulus(2'd1, 3, 32'h0, 1'b1);
    waitResponse(1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge tck);
      checkOutput("rsp_valid_held", bus.rsp_valid, 1);
      checkOutput("cmd_ready_held_low", bus.cmd_ready, 0);
    end
    ackResponse();

    $display("[TB] Reset during DR shift bit 10");
    tdo_high = 1'b1;
    applyStimulus(2'd3, 32, $urandom, 1'b0);
    repeat (13) @(negedge tck);
    checkOutput("pre_abort_tap_state", tap_state, TAP_SHIFT_DR);
    checkOutput("pre_abort_busy", busy, 1);
    trst = 1'b0;
    #1;
    checkOutput("abort_tms", tms, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_tap_state", tap_state, TAP_TEST_LOGIC_RESET);
    checkOutput("abort_rsp_valid", bus.rsp_valid, 0);
    @(negedge tck);
    trst = 1'b1;
    in_tlr = 1'b1;
    tdo_high = 1'b0;
    saw_rsp = 1'b0;
    repeat (6) begin
      @(negedge tck);
      if (bus.rsp_valid === 1'b1) saw_rsp = 1'b1;
    end
    checkOutput("no_rsp_after_abort", saw_rsp, 0);

    $display("[TB] IR scan after abort, ENTER expected");
    applyStimulus(2'd2, 8, $urandom, 1'b1);
    waitResponse(1'b1);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_scan_sequencer.md
Name: jtag_scan_sequencer

Overview:
Host-side scan engine on the tck domain. It drives tms/tdi into a JTAG TAP and samples tdo. It accepts high-level commands (TAP reset, idle cycles, IR scan, DR scan), generates the exact TMS/TDI bit sequences, and returns the captured TDO bits. It keeps a mirror of the target TAP state, so every command starts and ends in RunTestOrIdle (or TestLogicReset straight after reset). It sits between a debug/bench command source and the TAP state machine.

Parameters:
MAX_LEN, 32, maximum scan length in bits; sets the widths of cmd_data and rsp_data.
LEN_W, 8, width of cmd_len; must cover MAX_LEN and the idle-cycle count.

Ports:
tck  in  1  scan clock; all state changes on its rising edge
trst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=RESET, 1=IDLE, 2=IR_SCAN, 3=DR_SCAN
cmd_len  in  LEN_W  scan bit count, or idle cycle count
cmd_data  in  MAX_LEN  TDI bits, shifted LSB first
rsp_valid  out  1  response available; held until rsp_ready
rsp_ready  in  1  response consumed
rsp_data  out  MAX_LEN  captured TDO bits, bit k = k-th shifted bit; upper bits 0
rsp_err  out  1  command rejected (bad length)
tms  out  1  registered TMS to target
tdi  out  1  registered TDI to target
tdo  in  1  TDO from target
tap_state  out  5  mirrored TAP state (shared encoding)
busy  out  1  high from command accept until rsp_valid rises

Behaviour:
- Reset (trst low, asynchronous): tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, tap_state=TestLogicReset, FSM=IDLE. The next edge after release gives cmd_ready=1.
- Mid-operation reset: the command is abandoned, no response is produced, and the state is as above.
- FSM states: IDLE, ENTER, PRE, SHIFT, POST, RUN, RESP.
- cmd_ready=1 only in IDLE. Accepting a command moves to the command's first state on the next edge.
- tms/tdi are registers. The value presented in cycle c is what the target samples at the end of cycle c.
- tdo is sampled at the end of every SHIFT cycle into bit index k of the capture register.
- ENTER: before IR_SCAN, DR_SCAN or IDLE, if tap_state=TestLogicReset, insert one cycle with tms=0 to reach RunTestOrIdle. Otherwise skip ENTER.
- RESET: 5 cycles tms=1, then 1 cycle tms=0. Ends in RunTestOrIdle. rsp_data=0.
- IDLE: cmd_len cycles with tms=0. cmd_len=0 goes straight to RESP.
- IR_SCAN PRE: tms 1,1,0,0 (SelectDrScan, SelectIrScan, CaptureIr, ShiftIr).
- DR_SCAN PRE: tms 1,0,0 (SelectDrScan, CaptureDr, ShiftDr).
- SHIFT: N=cmd_len cycles. tdi=cmd_data[k]. tms=0 for k<N-1 and tms=1 for k=N-1 (to Exit1).
- POST: tms=1 (Update), then tms=0 (RunTestOrIdle).
- Scan latency: IR = 4+N+2 cycles, DR = 3+N+2 cycles, plus 1 if ENTER is inserted. rsp_valid rises the edge after the last POST cycle.
- Idle tms between commands: tms=0 in IDLE after any completed command; tms=1 only after reset.
- Length check: IR/DR with cmd_len=0 or cmd_len>MAX_LEN gives no TAP activity, tms/tap_state unchanged, RESP with rsp_err=1 and rsp_data=0.
- RESP: rsp_valid=1 and rsp_data/rsp_err stable until rsp_ready. rsp_valid && rsp_ready at the same edge returns to IDLE, so cmd_ready=1 the following cycle.
- A tdo capture at bit k ≥ N never occurs; unused rsp_data bits read 0.
- tap_state updates every edge from the presented tms, using the standard IEEE 1149.1 transitions.
  - Exit2Dr -> ShiftDr / UpdateDr.
  - Exit2Ir -> ShiftIr / UpdateIr.

Decomposition:
- Shared package jtag_pkg: 5-bit TAP state encodings (TestLogicReset=0 … UpdateIr), cmd_op encodings, and a next-state function next_tap_state(state, tms).
- Sub-module jtag_tap_mirror: registered TAP tracker. Inputs tck, trst, tms; output tap_state. It uses the same reset semantics.

Test Plan:
- Release reset, issue RESET -> tms = 1,1,1,1,1,0; tap_state=RunTestOrIdle; rsp_valid after 6 cycles, rsp_data=0, rsp_err=0.
- From reset, IR_SCAN len=5, data=0x16, tdo looped to tdi -> ENTER then tms 0,1,1,0,0,0,0,0,0,1,1,0 and tdi in SHIFT 0,1,1,0,1; rsp_data=0x16; 12 cycles to rsp_valid.
- DR_SCAN len=32, data=0xDEADBEEF, tdo tied 1 -> 3+32+2=37 cycles; rsp_data=0xFFFFFFFF; end state RunTestOrIdle.
- DR_SCAN len=0, then len=33 -> each gives rsp_err=1, tms held, tap_state unchanged, response the cycle after accept.
- IDLE len=3 with rsp_ready low 4 cycles -> 3 cycles tms=0; rsp_valid held; cmd_ready=0 until the handshake, then 1 the next cycle.
- Assert trst low during SHIFT bit 10 of a DR scan -> same-cycle tms=1, busy=0, tap_state=TestLogicReset, no rsp_valid; a following IR scan inserts ENTER.
